// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the multiply/divide unit: operation codes,
// FSM state encoding and small decode helpers.
package cpu_pkg;

   // Multiply/divide operation codes as driven by the control unit
   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   // Multiply/divide sequencer states
   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_RUN  = 2'b01,
      MD_FIN  = 2'b10
   } md_state_e;

   // True for DIV and DIVU
   function automatic logic md_is_div(input logic [1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for the two's-complement variants (MULT, DIV)
   function automatic logic md_is_signed(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation for the multiply/divide unit.
// In split mode the upper and lower WIDTH-bit halves are negated independently
// (operand absolute values, or remainder/quotient correction). In wide mode the
// whole 2*WIDTH-bit value is negated as one number (product correction) under
// control of neg_hi_i.
module md_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] val_i,
   input  logic               wide_i,
   input  logic               neg_hi_i,
   input  logic               neg_lo_i,
   output logic [2*WIDTH-1:0] res_o
);

   logic [2*WIDTH-1:0] neg_full_s;
   logic [WIDTH-1:0]   neg_hi_s;
   logic [WIDTH-1:0]   neg_lo_s;

   // Select between the value and its negation, full width or per half
   always_comb begin
      neg_full_s = -val_i;
      neg_hi_s   = -val_i[2*WIDTH-1:WIDTH];
      neg_lo_s   = -val_i[WIDTH-1:0];
      res_o      = val_i;
      if (wide_i) begin
         if (neg_hi_i) begin
            res_o = neg_full_s;
         end else begin
            res_o = val_i;
         end
      end else begin
         if (neg_hi_i) begin
            res_o[2*WIDTH-1:WIDTH] = neg_hi_s;
         end else begin
            res_o[2*WIDTH-1:WIDTH] = val_i[2*WIDTH-1:WIDTH];
         end
         if (neg_lo_i) begin
            res_o[WIDTH-1:0] = neg_lo_s;
         end else begin
            res_o[WIDTH-1:0] = val_i[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit producing the HI/LO pair.
// Operands are reduced to magnitudes on acceptance, WIDTH shift-add or
// restoring-subtract steps run on a single 2*WIDTH working register, and the
// sign is restored when the result is written. HI/LO only change on the
// completion edge of a non-faulting operation (or on reset).
module mult_div_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_e          state_q;
   logic [1:0]         op_q;
   logic               neg_a_q;
   logic               neg_b_q;
   logic               dz_pend_q;
   logic [WIDTH-1:0]   mag_b_q;
   logic [2*WIDTH-1:0] work_q;
   logic [2*WIDTH-1:0] work_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               done_q;
   logic               div_zero_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               in_signed_s;
   logic               in_neg_a_s;
   logic               in_neg_b_s;
   logic [2*WIDTH-1:0] op_mag_s;
   logic [WIDTH-1:0]   mag_a_s;
   logic [WIDTH-1:0]   mag_b_s;
   logic               in_div_zero_s;

   logic               res_wide_s;
   logic               res_neg_hi_s;
   logic               res_neg_lo_s;
   logic [2*WIDTH-1:0] res_fix_s;

   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_sh_s;
   logic [WIDTH-1:0]   div_diff_s;
   logic               div_ge_s;

   // Sign flags of the incoming operands and divide-by-zero detection
   always_comb begin
      in_signed_s   = md_is_signed(op);
      in_neg_a_s    = in_signed_s & a[WIDTH-1];
      in_neg_b_s    = in_signed_s & b[WIDTH-1];
      in_div_zero_s = md_is_div(op) && (b == {WIDTH{1'b0}});
      mag_a_s       = op_mag_s[WIDTH-1:0];
      mag_b_s       = op_mag_s[2*WIDTH-1:WIDTH];
   end

   md_sign_fix #(.WIDTH(WIDTH)) u_op_fix (
      .val_i    ({b, a}),
      .wide_i   (1'b0),
      .neg_hi_i (in_neg_b_s),
      .neg_lo_i (in_neg_a_s),
      .res_o    (op_mag_s)
   );

   // Result sign: product by operand signs, remainder follows the dividend
   always_comb begin
      res_wide_s   = ~md_is_div(op_q);
      res_neg_lo_s = neg_a_q ^ neg_b_q;
      if (md_is_div(op_q)) begin
         res_neg_hi_s = neg_a_q;
      end else begin
         res_neg_hi_s = neg_a_q ^ neg_b_q;
      end
   end

   md_sign_fix #(.WIDTH(WIDTH)) u_res_fix (
      .val_i    (work_q),
      .wide_i   (res_wide_s),
      .neg_hi_i (res_neg_hi_s),
      .neg_lo_i (res_neg_lo_s),
      .res_o    (res_fix_s)
   );

   // One iteration: shift-add multiply or restoring-divide step on magnitudes
   always_comb begin
      if (work_q[0]) begin
         mul_sum_s = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_b_q};
      end else begin
         mul_sum_s = {1'b0, work_q[2*WIDTH-1:WIDTH]};
      end
      div_sh_s   = work_q[2*WIDTH-1:WIDTH-1];
      div_ge_s   = (div_sh_s >= {1'b0, mag_b_q});
      div_diff_s = div_sh_s[WIDTH-1:0] - mag_b_q;
      if (md_is_div(op_q)) begin
         if (div_ge_s) begin
            work_d = {div_diff_s, work_q[WIDTH-2:0], 1'b1};
         end else begin
            work_d = {div_sh_s[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         work_d = {mul_sum_s, work_q[WIDTH-1:1]};
      end
   end

   // Sequencer with registered handshake and result outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= MD_IDLE;
         op_q       <= MD_MULT;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         dz_pend_q  <= 1'b0;
         mag_b_q    <= {WIDTH{1'b0}};
         work_q     <= {(2*WIDTH){1'b0}};
         cnt_q      <= CNT_ZERO;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= {WIDTH{1'b0}};
         lo_q       <= {WIDTH{1'b0}};
      end else begin
         done_q <= 1'b0;
         case (state_q)
            MD_IDLE: begin
               if (start) begin
                  op_q       <= op;
                  neg_a_q    <= in_neg_a_s;
                  neg_b_q    <= in_neg_b_s;
                  mag_b_q    <= mag_b_s;
                  work_q     <= {{WIDTH{1'b0}}, mag_a_s};
                  cnt_q      <= CNT_ZERO;
                  busy_q     <= 1'b1;
                  div_zero_q <= 1'b0;
                  dz_pend_q  <= in_div_zero_s;
                  if (in_div_zero_s) begin
                     state_q <= MD_FIN;
                  end else begin
                     state_q <= MD_RUN;
                  end
               end else begin
                  state_q <= MD_IDLE;
               end
            end
            MD_RUN: begin
               work_q <= work_d;
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= CNT_ZERO;
                  state_q <= MD_FIN;
               end else begin
                  cnt_q   <= cnt_q + CNT_ONE;
                  state_q <= MD_RUN;
               end
            end
            MD_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= MD_IDLE;
               if (dz_pend_q) begin
                  div_zero_q <= 1'b1;
               end else begin
                  hi_q <= res_fix_s[2*WIDTH-1:WIDTH];
                  lo_q <= res_fix_s[WIDTH-1:0];
               end
            end
            default: begin
               busy_q  <= 1'b0;
               cnt_q   <= CNT_ZERO;
               state_q <= MD_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32) with an arithmetic reference
// model checked every cycle, plus literal expectations per operation.
module tb_mult_div_unit;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         div_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clock = ~clock;

   mult_div_unit #(.WIDTH(W)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Architectural result {hi,lo} from plain 64-bit arithmetic
   function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx;
      longint sy;
      longint ux;
      longint uy;
      longint q;
      longint r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'd0, x});
      uy = longint'({32'd0, y});
      case (o)
         2'b00: return sx * sy;
         2'b01: return ux * uy;
         2'b10: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
         default: begin q = ux / uy; r = ux % uy; return {r[31:0], q[31:0]}; end
      endcase
   endfunction

   // Reference model state
   logic        m_busy;
   logic        m_done;
   logic        m_dz;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   int          m_left;
   logic        p_dz;
   logic [63:0] p_res;

   // Model: accept when idle, result appears WIDTH+1 edges later (1 for /0)
   always @(posedge clock) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_dz   <= 1'b0;
         m_hi   <= 32'd0;
         m_lo   <= 32'd0;
         m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               if (p_dz) begin
                  m_dz <= 1'b1;
               end else begin
                  m_hi <= p_res[63:32];
                  m_lo <= p_res[31:0];
               end
            end
         end else if (start) begin
            m_busy <= 1'b1;
            m_dz   <= 1'b0;
            if (op[1] && (b == 32'd0)) begin
               p_dz   <= 1'b1;
               p_res  <= 64'd0;
               m_left <= 1;
            end else begin
               p_dz   <= 1'b0;
               p_res  <= ref_res(op, a, b);
               m_left <= W + 1;
            end
         end
      end
   end

   // Compare DUT against the model on every falling edge
   always @(negedge clock) begin
      if (chk_en) begin
         chk("cyc_busy", 32'(busy), 32'(m_busy));
         chk("cyc_done", 32'(done), 32'(m_done));
         chk("cyc_div_zero", 32'(div_zero), 32'(m_dz));
         chk("cyc_hi", hi, m_hi);
         chk("cyc_lo", lo, m_lo);
      end
   end

   // Issue one operation and check its literal result, latency and busy span
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input bit fast, input bit poke, input string nm);
      int n;
      int bcnt;
      bit seen;
      int exp_lat;
      if (!fast) @(negedge clock);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      n     = 0;
      bcnt  = 0;
      seen  = 1'b0;
      exp_lat = edz ? 1 : W + 1;
      while (!seen && n < 100) begin
         @(negedge clock);
         n++;
         if (busy) bcnt++;
         if (n == 1) begin
            chk({nm, "_dz_clear"}, 32'(div_zero), 32'd0);
            start = 1'b0;
            a     = $urandom;
            b     = $urandom;
            op    = 2'($urandom_range(0, 3));
         end
         if (poke && n == 5) begin
            start = 1'b1;
            op    = 2'b11;
            a     = 32'd100;
            b     = 32'd3;
         end
         if (poke && n == 6) start = 1'b0;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: no done within %0d cycles", nm, n);
      end else begin
         chk({nm, "_latency"}, 32'(n - 1), 32'(exp_lat));
         chk({nm, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat));
         chk({nm, "_hi"}, hi, eh);
         chk({nm, "_lo"}, lo, el);
         chk({nm, "_div_zero"}, 32'(div_zero), 32'(edz));
      end
   endtask

   initial begin
      bit saw_done;
      reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = 32'd0;
      b     = 32'd0;
      repeat (3) @(negedge clock);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_div_zero", 32'(div_zero), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk_en = 1'b1;
      reset  = 1'b0;

      run_op(2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0, "mult_neg");
      run_op(2'b01, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, "multu");
      run_op(2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, "mult_b2b");
      run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b0, "mult_min");
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, "div_neg");
      run_op(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 1'b1, 1'b0, "divu_b2b");
      run_op(2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 1'b0, 1'b0, 1'b0, "div_negneg");
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b0, 1'b0, "div_min");
      run_op(2'b11, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999, 1'b0, 1'b0, 1'b0, "divu_big");
      run_op(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 1'b0, 1'b0, "divu");
      run_op(2'b11, 32'd7, 32'd0, 32'd1, 32'd3, 1'b1, 1'b0, 1'b0, "divu_zero");

      repeat (5) @(negedge clock);
      chk("dz_hold_flag", 32'(div_zero), 32'd1);
      chk("dz_hold_hi", hi, 32'd1);
      chk("dz_hold_lo", lo, 32'd3);

      run_op(2'b01, 32'd1000, 32'd1000, 32'd0, 32'h000F4240, 1'b0, 1'b0, 1'b1, "start_ignored");

      // Reset in the middle of an operation
      @(negedge clock);
      start = 1'b1;
      op    = 2'b00;
      a     = 32'd5;
      b     = 32'd6;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      reset    = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (done) saw_done = 1'b1;
      end
      chk("midrst_no_done", 32'(saw_done), 32'd0);

      run_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0, 1'b0, "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
